// File: rtl/m_unit_pkg.sv
// Shared definitions for the M-extension controller: FSM states, RV32M funct3
// codes, datapath mux encodings and op-class helpers.
package m_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL_OPS,
        MUL_WAIT,
        MUL_WB,
        DIV_STEP,
        DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int CNT_W = 5;

    localparam int MUX_MULTA_W = 2;
    localparam int MUX_MULTB_W = 2;
    localparam int MUX_R_W     = 3;
    localparam int MUX_D_W     = 2;
    localparam int MUX_Z_W     = 2;

    localparam logic [MUX_MULTA_W-1:0] MULTA_ZERO     = 2'd0;
    localparam logic [MUX_MULTA_W-1:0] MULTA_UNSIGNED = 2'd1;
    localparam logic [MUX_MULTA_W-1:0] MULTA_SIGNED   = 2'd2;

    localparam logic [MUX_MULTB_W-1:0] MULTB_ZERO     = 2'd0;
    localparam logic [MUX_MULTB_W-1:0] MULTB_UNSIGNED = 2'd1;
    localparam logic [MUX_MULTB_W-1:0] MULTB_SIGNED   = 2'd2;

    localparam logic [MUX_R_W-1:0] R_KEEP       = 3'd0;
    localparam logic [MUX_R_W-1:0] R_A          = 3'd1;
    localparam logic [MUX_R_W-1:0] R_A_NEG      = 3'd2;
    localparam logic [MUX_R_W-1:0] R_MULT_LOWER = 3'd3;
    localparam logic [MUX_R_W-1:0] R_SUB_KEEP   = 3'd4;

    localparam logic [MUX_D_W-1:0] D_KEEP  = 2'd0;
    localparam logic [MUX_D_W-1:0] D_B     = 2'd1;
    localparam logic [MUX_D_W-1:0] D_B_NEG = 2'd2;
    localparam logic [MUX_D_W-1:0] D_SHR   = 2'd3;

    localparam logic [MUX_Z_W-1:0] Z_KEEP       = 2'd0;
    localparam logic [MUX_Z_W-1:0] Z_ZERO       = 2'd1;
    localparam logic [MUX_Z_W-1:0] Z_MULT_UPPER = 2'd2;
    localparam logic [MUX_Z_W-1:0] Z_SHL_ADD    = 2'd3;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // For divides "signed" covers both operands (DIV/REM have funct3[0]=0).
    function automatic logic is_signed_a(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3 == F3_MULH || f3 == F3_MULHSU);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3 == F3_MULH);
    endfunction

endpackage

// File: rtl/m_iter_counter.sv
// Loadable down-counter used both for the multiplier wait and the divide steps.
module m_iter_counter
    import m_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/m_unit_controller.sv
// Sequencing FSM for the M-extension register block: drives the R/D/Z and
// multiplier operand selects per cycle and flags completion to writeback.
module m_unit_controller
    import m_unit_pkg::*;
#(
    parameter int MUL_LATENCY = 1,
    parameter int DIV_STEPS   = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [2:0]             funct3,
    input  logic                   rs1_msb,
    input  logic                   rs2_msb,
    input  logic                   rs2_zero,
    input  logic                   flush,
    input  logic                   sub_neg,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic                   result_sel,
    output logic                   result_neg,
    output logic [MUX_MULTA_W-1:0] mux_multA,
    output logic [MUX_MULTB_W-1:0] mux_multB,
    output logic [MUX_R_W-1:0]     mux_R,
    output logic [MUX_D_W-1:0]     mux_D,
    output logic [MUX_Z_W-1:0]     mux_Z,
    output logic [2:0]             dbg_state
);

    state_t           state, next_state;
    logic [2:0]       op_q;
    logic             s1_q, s2_q, zero_q;
    logic             accept;
    logic             cnt_last;
    logic [CNT_W-1:0] iter_cnt;
    logic             unused;

    // The borrow is consumed inside the datapath's SUB_KEEP mux, not here.
    assign unused = ^{sub_neg, iter_cnt};

    assign ready     = (state == IDLE);
    assign busy      = ~ready;
    assign accept    = ready & start & ~flush;
    assign dbg_state = state;

    m_iter_counter u_iter_counter (
        .clk      (clk),
        .rst      (resetn),
        .load     (state == LOAD),
        .en       (state == MUL_WAIT || state == DIV_STEP),
        .load_val (is_div(op_q) ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MUL_LATENCY - 1)),
        .cnt      (iter_cnt),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state  <= IDLE;
            op_q   <= F3_MUL;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q   <= funct3;
                s1_q   <= is_div(funct3) & is_signed_a(funct3) & rs1_msb;
                s2_q   <= is_div(funct3) & is_signed_b(funct3) & rs2_msb;
                zero_q <= rs2_zero;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept) next_state = LOAD;
            LOAD:     next_state = is_div(op_q) ? DIV_STEP : MUL_OPS;
            MUL_OPS:  next_state = MUL_WAIT;
            MUL_WAIT: if (cnt_last) next_state = MUL_WB;
            MUL_WB:   next_state = DONE;
            DIV_STEP: if (cnt_last) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (flush && state != IDLE) next_state = IDLE;
    end

    // Flags are registered on entry to DONE so they line up with the done pulse.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            done       <= 1'b0;
            result_sel <= 1'b0;
            result_neg <= 1'b0;
        end else begin
            done       <= (next_state == DONE);
            result_sel <= 1'b0;
            result_neg <= 1'b0;
            if (next_state == DONE) begin
                result_sel <= (op_q == F3_MUL) || (op_q == F3_REM) || (op_q == F3_REMU);
                if (op_q == F3_DIV) result_neg <= (s1_q ^ s2_q) & ~zero_q;
                if (op_q == F3_REM) result_neg <= s1_q;
            end
        end
    end

    always_comb begin
        mux_multA = MULTA_ZERO;
        mux_multB = MULTB_ZERO;
        mux_R     = R_KEEP;
        mux_D     = D_KEEP;
        mux_Z     = Z_KEEP;
        if (!flush) begin
            case (state)
                LOAD: begin
                    if (is_div(op_q)) begin
                        mux_R = s1_q ? R_A_NEG : R_A;
                        mux_D = s2_q ? D_B_NEG : D_B;
                        mux_Z = Z_ZERO;
                    end else begin
                        mux_R = R_A;
                        mux_D = D_B;
                    end
                end
                MUL_OPS, MUL_WAIT, MUL_WB: begin
                    mux_multA = is_signed_a(op_q) ? MULTA_SIGNED : MULTA_UNSIGNED;
                    mux_multB = is_signed_b(op_q) ? MULTB_SIGNED : MULTB_UNSIGNED;
                    if (state == MUL_WB) begin
                        mux_R = R_MULT_LOWER;
                        mux_Z = Z_MULT_UPPER;
                    end
                end
                DIV_STEP: begin
                    mux_R = R_SUB_KEEP;
                    mux_Z = Z_SHL_ADD;
                    mux_D = D_SHR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_unit_controller.sv
// Bench for m_unit_controller: a behavioural R/D/Z/P datapath follows the mux
// selects, and table vectors compare writeback value, latency and result flags.
module tb_m_unit_controller;
    import m_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, start, flush;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        sub_neg;
    logic        ready, busy, done, result_sel, result_neg;
    logic [MUX_MULTA_W-1:0] mux_multA;
    logic [MUX_MULTB_W-1:0] mux_multB;
    logic [MUX_R_W-1:0]     mux_R;
    logic [MUX_D_W-1:0]     mux_D;
    logic [MUX_Z_W-1:0]     mux_Z;
    logic [2:0]             dbg_state;

    int total = 0;
    int bad   = 0;

    m_unit_controller dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .funct3     (funct3),
        .rs1_msb    (rs1[31]),
        .rs2_msb    (rs2[31]),
        .rs2_zero   (rs2 == 32'd0),
        .flush      (flush),
        .sub_neg    (sub_neg),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .result_sel (result_sel),
        .result_neg (result_neg),
        .mux_multA  (mux_multA),
        .mux_multB  (mux_multB),
        .mux_R      (mux_R),
        .mux_D      (mux_D),
        .mux_Z      (mux_Z),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: 64-bit R/D for restoring division, D loaded as B<<31.
    logic [63:0] r = '0, d = '0, ma = '0, mb = '0, p = '0;
    logic [31:0] z = '0;
    assign sub_neg = (r < d);

    always @(posedge clk) begin
        case (mux_R)
            R_A:          r <= {32'd0, rs1};
            R_A_NEG:      r <= {32'd0, ~rs1 + 32'd1};
            R_MULT_LOWER: r <= {32'd0, p[31:0]};
            R_SUB_KEEP:   if (!(r < d)) r <= r - d;
            default: ;
        endcase
        case (mux_D)
            D_B:     d <= {1'b0, rs2, 31'd0};
            D_B_NEG: d <= {1'b0, ~rs2 + 32'd1, 31'd0};
            D_SHR:   d <= d >> 1;
            default: ;
        endcase
        case (mux_Z)
            Z_ZERO:       z <= 32'd0;
            Z_MULT_UPPER: z <= p[63:32];
            Z_SHL_ADD:    z <= {z[30:0], ~(r < d)};
            default: ;
        endcase
        case (mux_multA)
            MULTA_UNSIGNED: ma <= {32'd0, r[31:0]};
            MULTA_SIGNED:   ma <= {{32{r[31]}}, r[31:0]};
            default:        ma <= '0;
        endcase
        case (mux_multB)
            MULTB_UNSIGNED: mb <= {32'd0, d[62:31]};
            MULTB_SIGNED:   mb <= {{32{d[62]}}, d[62:31]};
            default:        mb <= '0;
        endcase
        p <= ma * mb;
    end

    // done and ready must never be high together.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            total++;
            if (ready !== 1'b0) begin
                bad++;
                $display("FAIL done_ready_overlap actual=%b required=0", ready);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wb;
        int          lat;
        logic        sel;
        logic        neg;
    } vec_t;

    vec_t vecs[15];

    // Issues one op; optionally pokes a second start while busy.
    task automatic run_op(input vec_t v, input string name, input bit poke);
        int cyc;
        bit got;
        logic [31:0] wb;
        @(negedge clk);
        funct3 = v.f3;
        rs1    = v.a;
        rs2    = v.b;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        got = 0;
        while (cyc < 80) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            if (poke && cyc == 3) begin
                start  = 1'b1;
                funct3 = F3_MULHU;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end else begin
            wb = result_sel ? r[31:0] : z;
            if (result_neg) wb = ~wb + 32'd1;
            check({name, "_latency"}, 32'(cyc), 32'(v.lat));
            check({name, "_sel"}, 32'(result_sel), 32'(v.sel));
            check({name, "_neg"}, 32'(result_neg), 32'(v.neg));
            check({name, "_wb"}, wb, v.wb);
        end
    endtask

    initial begin
        int done_seen;
        resetn = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = F3_MUL;
        rs1    = '0;
        rs2    = '0;

        vecs[0]  = '{F3_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 5,  1'b0, 1'b0};
        vecs[1]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  1'b0, 1'b0};
        vecs[2]  = '{F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5,  1'b1, 1'b0};
        vecs[3]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5,  1'b0, 1'b0};
        vecs[4]  = '{F3_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34, 1'b0, 1'b1};
        vecs[5]  = '{F3_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, 1'b1, 1'b1};
        vecs[6]  = '{F3_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 34, 1'b0, 1'b0};
        vecs[7]  = '{F3_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 34, 1'b1, 1'b1};
        vecs[8]  = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 1'b0, 1'b0};
        vecs[9]  = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 1'b1, 1'b1};
        vecs[10] = '{F3_REMU,   32'd100,      32'd7,        32'd2,        34, 1'b1, 1'b0};
        vecs[11] = '{F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0, 1'b1};
        vecs[12] = '{F3_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 34, 1'b0, 1'b0};
        vecs[13] = '{F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 5,  1'b1, 1'b0};
        vecs[14] = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 5,  1'b0, 1'b0};

        #2;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", {30'd0, result_sel, result_neg}, 32'd0);
        check("rst_mux_rdz", {25'd0, mux_R, mux_D, mux_Z}, {25'd0, R_KEEP, D_KEEP, Z_KEEP});
        check("rst_mux_mult", {28'd0, mux_multA, mux_multB}, {28'd0, MULTA_ZERO, MULTB_ZERO});
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // start together with flush in IDLE is dropped
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_state", 32'(dbg_state), 32'(IDLE));

        // flush at DIV_STEP 10 (cycle 12)
        @(negedge clk);
        funct3 = F3_DIV;
        rs1    = 32'd1000;
        rs2    = 32'd3;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("flush_pre_state", 32'(dbg_state), 32'(DIV_STEP));
        flush = 1'b1;
        check("flush_pre_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_state", 32'(dbg_state), 32'(IDLE));
        check("flush_ready", 32'(ready), 32'd1);
        check("flush_done", 32'(done), 32'd0);

        // back-to-back start after flush, with a start poked while busy
        run_op(vecs[4], "after_flush", 1'b1);
        run_op(vecs[0], "after_poke", 1'b0);

        // asynchronous reset during MUL_WAIT
        @(negedge clk);
        funct3 = F3_MUL;
        rs1    = 32'd3;
        rs2    = 32'd4;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mid_pre_state", 32'(dbg_state), 32'(MUL_WAIT));
        resetn = 1'b1;
        #1;
        check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
        check("rst_mid_ready", 32'(ready), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("rst_mid_no_done", 32'(done_seen), 32'd0);

        run_op(vecs[13], "after_reset", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
